// File: rtl/bcd_disp_sched.sv
// bcd_disp_sched
//   Shares one external binary-to-BCD converter between two requesters and
//   scans the stored result of one of them onto a 4-digit multiplexed
//   display.
//
// Ports
//   clk                 system clock, all state on the rising edge
//   rst                 asynchronous active-low reset
//   req[1:0]            per-requester conversion request (level)
//   val0, val1          14-bit binary operands, stable while the matching req is high
//   ack[1:0]            one-cycle completion pulse to the granted requester
//   disp_sel            selects which requester's digit bank is scanned out
//   conv_start          one-cycle start pulse to the converter
//   conv_value          converter operand, clamped to 9999, held until done
//   conv_done           converter completion, only looked at while waiting
//   conv_a..conv_d      converter digits, thousands down to ones
//   an[3:0]             active-low digit enables
//   bcd_out[3:0]        digit for the currently enabled position
//   busy                controller is not idle
//   err                 sticky conversion-timeout flag
//   dbg_state[1:0]      controller state, for observation only
//
// Handshakes: a requester raises req[i] with val<i> stable and keeps it high
// until it sees ack[i]. The grant is decided in IDLE from the live req
// value; the converter sees conv_start for one cycle with conv_value already
// valid, and answers with conv_done while the controller waits. A request
// dropped after the grant still completes and is still acknowledged.
module bcd_disp_sched #(
  parameter int SCAN_DIV     = 1000,
  parameter int CONV_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  logic [13:0] val0,
  input  logic [13:0] val1,
  output logic [1:0]  ack,
  input  logic        disp_sel,
  output logic        conv_start,
  output logic [13:0] conv_value,
  input  logic        conv_done,
  input  logic [3:0]  conv_a,
  input  logic [3:0]  conv_b,
  input  logic [3:0]  conv_c,
  input  logic [3:0]  conv_d,
  output logic [3:0]  an,
  output logic [3:0]  bcd_out,
  output logic        busy,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    STORE = 2'd3
  } state_t;

  localparam int TW = $clog2(CONV_TIMEOUT + 1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(CONV_TIMEOUT - 1);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  state_t        state, state_nx;
  logic          gnt, gnt_nx;     // index of the granted requester
  logic          rr_pri;          // requester that wins when both ask
  logic          latch_en;
  logic          wait_expired;
  logic          timed_out;       // last wait ended without conv_done
  logic [TW-1:0] wait_cnt;
  logic [13:0]   sel_val;
  logic [13:0]   clamped;
  logic [15:0]   bank0, bank1;
  logic [15:0]   shown;
  logic [SW-1:0] scan_cnt;
  logic [1:0]    scan_idx;

  assign wait_expired = (wait_cnt == WAIT_LAST);
  assign sel_val      = gnt_nx ? val1 : val0;
  assign clamped      = (sel_val > 14'd9999) ? 14'd9999 : sel_val;

  always_comb begin
    state_nx = state;
    gnt_nx   = gnt;
    latch_en = 1'b0;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          latch_en = 1'b1;
          state_nx = START;
          gnt_nx   = (req == 2'b11) ? rr_pri : req[1];
        end
      end
      START: state_nx = WAIT;
      WAIT: begin
        if (conv_done || wait_expired) state_nx = STORE;
      end
      STORE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Moore outputs: all decode the current state, so reset clears them at once.
  assign conv_start = (state == START);
  assign busy       = (state != IDLE);
  assign ack        = (state == STORE) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      rr_pri     <= 1'b0;
      conv_value <= '0;
      wait_cnt   <= '0;
      timed_out  <= 1'b0;
      err        <= 1'b0;
      bank0      <= '0;
      bank1      <= '0;
    end else begin
      state <= state_nx;
      gnt   <= gnt_nx;
      if (latch_en) begin
        conv_value <= clamped;
        rr_pri     <= ~gnt_nx;
      end
      wait_cnt <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      // Only meaningful on the WAIT->STORE step; STORE always follows.
      if (state == WAIT) timed_out <= !conv_done && wait_expired;
      if (state == WAIT && !conv_done && wait_expired) err <= 1'b1;
      if (state == STORE && !timed_out) begin
        if (gnt) bank1 <= {conv_a, conv_b, conv_c, conv_d};
        else     bank0 <= {conv_a, conv_b, conv_c, conv_d};
      end
    end
  end

  // Display scan, free-running regardless of controller state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      scan_idx <= 2'd0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  assign shown = disp_sel ? bank1 : bank0;
  assign an    = ~(4'b0001 << scan_idx);

  always_comb begin
    bcd_out = shown[15:12];
    case (scan_idx)
      2'd0: bcd_out = shown[15:12];
      2'd1: bcd_out = shown[11:8];
      2'd2: bcd_out = shown[7:4];
      2'd3: bcd_out = shown[3:0];
      default: bcd_out = shown[15:12];
    endcase
  end

endmodule

// File: tb/tb_bcd_disp_sched.sv
// tb_bcd_disp_sched
//   Stimulus for bcd_disp_sched with a small-scan configuration, a modelled
//   BCD converter, a directed vector table, hand-written corner sequences and
//   randomized two-requester traffic. A reference model predicts grants,
//   operands, ack timing, digit banks, err and the scan pattern.
module tb_bcd_disp_sched;

  localparam int SCAN_DIV     = 4;
  localparam int CONV_TIMEOUT = 64;
  localparam int QW           = 48;  // {timeout, who, digits[15:0], due_cycle[29:0]}

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [1:0]  req;
  logic [13:0] val0, val1;
  logic [1:0]  ack;
  logic        disp_sel;
  logic        conv_start;
  logic [13:0] conv_value;
  logic        conv_done;
  logic [3:0]  conv_a, conv_b, conv_c, conv_d;
  logic [3:0]  an, bcd_out;
  logic        busy, err;
  logic [1:0]  dbg_state;

  assign req = {req1, req0};

  bcd_disp_sched #(.SCAN_DIV(SCAN_DIV), .CONV_TIMEOUT(CONV_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .val0(val0), .val1(val1), .ack(ack),
    .disp_sel(disp_sel), .conv_start(conv_start), .conv_value(conv_value),
    .conv_done(conv_done), .conv_a(conv_a), .conv_b(conv_b), .conv_c(conv_c),
    .conv_d(conv_d), .an(an), .bcd_out(bcd_out), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- check bookkeeping ----------------
  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int clampv(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // ---------------- converter model ----------------
  bit          en_done   = 1'b1;
  int          fixed_lat = 0;
  int          cur_lat   = 1;
  int          ccnt      = 0;
  bit          cpend     = 1'b0;
  logic [13:0] cv_cap;

  initial begin
    conv_done = 1'b0;
    {conv_a, conv_b, conv_c, conv_d} = 16'h0000;
    forever begin
      @(negedge clk);
      conv_done = 1'b0;
      if (conv_start) begin
        cv_cap  = conv_value;
        cur_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
        ccnt    = cur_lat;
        cpend   = 1'b1;
      end else if (cpend) begin
        ccnt--;
        if (ccnt == 0) begin
          cpend = 1'b0;
          if (en_done) begin
            conv_done = 1'b1;
            {conv_a, conv_b, conv_c, conv_d} = to_bcd(int'(cv_cap));
          end
        end
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int              cyc        = 0;
  int              ticks      = 0;
  logic [1:0]      req_s      = 2'b00;
  int              last_g     = -1;
  logic [15:0]     bank_m[2];
  logic            exp_err    = 1'b0;
  bit              inflight   = 1'b0;
  int              last_start = -100;
  logic [QW-1:0]   exp_q[$];

  // Posedge sampler: what the DUT saw on this edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      req_s = req;
      if (!rst) ticks = 0;
      else      ticks++;
    end
  end

  initial begin
    int          idx, who, v, due;
    logic [3:0]  exp_an, exp_d;
    logic [15:0] bk;
    logic [QW-1:0] e;
    bit          to;
    bank_m[0] = '0;
    bank_m[1] = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        exp_q.delete();
        last_g     = -1;
        bank_m[0]  = '0;
        bank_m[1]  = '0;
        exp_err    = 1'b0;
        inflight   = 1'b0;
        last_start = -100;
        ticks      = 0;
      end else begin
        // scan pattern from elapsed cycles since reset
        idx    = (ticks / SCAN_DIV) % 4;
        exp_an = ~(4'b0001 << idx);
        bk     = bank_m[disp_sel];
        exp_d  = bk[15 - 4*idx -: 4];
        check("scan_an", an, exp_an);
        check("scan_digit", bcd_out, exp_d);

        if (conv_start) begin
          check("start_spacing", 32'((cyc - last_start) >= 4), 1);
          check("start_has_req", 32'(req_s != 2'b00), 1);
          last_start = cyc;
          case (req_s)
            2'b10:   who = 1;
            2'b11:   who = (last_g == 0) ? 1 : 0;
            default: who = 0;
          endcase
          v = clampv(who ? int'(val1) : int'(val0));
          check("conv_value", conv_value, v);
          last_g   = who;
          inflight = 1'b1;
          to       = !en_done;
          due      = cyc + (to ? CONV_TIMEOUT + 1 : cur_lat + 1);
          exp_q.push_back({to, 1'(who), to_bcd(v), 30'(due)});
        end

        if (ack != 2'b00) begin
          check("ack_with_start", conv_start, 0);
          check("ack_onehot", 32'($onehot(ack)), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_ack", ack, 0);
          end else begin
            e = exp_q.pop_front();
            check("ack_bit", ack, e[46] ? 2'b10 : 2'b01);
            check("ack_latency", cyc, {2'b00, e[29:0]});
            if (e[47]) exp_err = 1'b1;
            else       bank_m[e[46]] = e[45:30];
          end
        end
        check("busy", busy, inflight);
        check("err", err, exp_err);
        if (ack != 2'b00) inflight = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input logic [1:0] r, input int v0, input int v1,
                         output logic [1:0] got_ack, output logic [13:0] got_cv,
                         output int starts);
    @(negedge clk);
    val0 = 14'(v0);
    val1 = 14'(v1);
    req0 = r[0];
    req1 = r[1];
    got_ack = 2'b00;
    got_cv  = '0;
    starts  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (conv_start) begin
        starts++;
        got_cv = conv_value;
      end
      if (ack != 2'b00) begin
        got_ack = ack;
        break;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  int drv_done = 0;

  task automatic drive(input int who, input int n);
    logic [13:0] v;
    bit          abort, got;
    int          hold;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      v = 14'($urandom_range(0, 16383));
      if (who == 0) begin val0 = v; req0 = 1'b1; end
      else          begin val1 = v; req1 = 1'b1; end
      abort = ($urandom_range(0, 7) == 0);
      hold  = $urandom_range(0, 5);
      got   = 1'b0;
      for (int i = 0; i < 300 && !got; i++) begin
        @(negedge clk);
        if (ack[who]) got = 1'b1;
        if (abort && i >= hold) break;
      end
      if (who == 0) req0 = 1'b0;
      else          req1 = 1'b0;
      if (abort) begin
        if (!got) repeat (100) @(negedge clk);
      end else begin
        check($sformatf("req%0d_served", who), got, 1);
      end
    end
    drv_done++;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0] r;
    int         v0;
    int         v1;
    int         lat;
    logic [1:0] eack;
    int         ecv;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [1:0]  ga;
    logic [13:0] gcv;
    int          st, n, acks;
    bit          found;
    logic [3:0]  prev_an;
    logic [3:0]  an_seq[4];
    logic [3:0]  dig_seq[4];
    logic [1:0]  grants[4];

    tbl[0] = '{2'b01,    36,     0, 10, 2'b01,   36};
    tbl[1] = '{2'b10,     0, 12000,  5, 2'b10, 9999};
    tbl[2] = '{2'b11,     7,     8,  3, 2'b01,    7};
    tbl[3] = '{2'b11, 10000,     5,  2, 2'b10,    5};
    tbl[4] = '{2'b01,  9999,     0,  1, 2'b01, 9999};
    tbl[5] = '{2'b10,     0,     0,  4, 2'b10,    0};
    tbl[6] = '{2'b11,  1234,  4321,  6, 2'b01, 1234};
    an_seq  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    dig_seq = '{4'd1, 4'd2, 4'd3, 4'd4};

    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; val0 = '0; val1 = '0; disp_sel = 1'b0;
    #1;
    check("rst_an", an, 4'b1110);
    check("rst_bcd", bcd_out, 0);
    check("rst_ack", ack, 0);
    check("rst_start", conv_start, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_conv_value", conv_value, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // table: single and contended requests, clamping, round-robin
    foreach (tbl[i]) begin
      fixed_lat = tbl[i].lat;
      run_txn(tbl[i].r, tbl[i].v0, tbl[i].v1, ga, gcv, st);
      check($sformatf("vec%0d_ack", i), ga, tbl[i].eack);
      check($sformatf("vec%0d_conv_value", i), gcv, tbl[i].ecv);
      check($sformatf("vec%0d_starts", i), st, 1);
    end
    fixed_lat = 0;

    // scan of bank0 = 1234 on requester 0
    disp_sel = 1'b0;
    found    = 1'b0;
    prev_an  = an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110 && prev_an == 4'b0111) found = 1'b1;
      else prev_an = an;
    end
    check("scan_sync", found, 1);
    if (found) begin
      for (int k = 0; k <= 16; k++) begin
        check($sformatf("scan_seq_an%0d", k), an, an_seq[(k / 4) % 4]);
        check($sformatf("scan_seq_bcd%0d", k), bcd_out, dig_seq[(k / 4) % 4]);
        @(negedge clk);
      end
    end

    // converter never answers: timeout, err sticky, bank untouched
    @(negedge clk);
    en_done = 1'b0;
    val1 = 14'd55;
    req1 = 1'b1;
    n = 0; ga = 2'b00; st = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (conv_start) st = 1;
      else if (st != 0) n++;
      if (ack != 2'b00) begin
        ga = ack;
        check("timeout_err", err, 1);
        break;
      end
    end
    req1 = 1'b0;
    en_done = 1'b1;
    check("timeout_ack", ga, 2'b10);
    check("timeout_latency", n, CONV_TIMEOUT + 1);
    run_txn(2'b01, 42, 0, ga, gcv, st);
    check("after_timeout_ack", ga, 2'b01);
    check("after_timeout_cv", gcv, 42);
    check("err_sticky", err, 1);

    // reset during WAIT, late conv_done ignored
    @(negedge clk);
    fixed_lat = 20;
    val0 = 14'd77;
    req0 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (conv_start) found = 1'b1;
    end
    check("rstw_started", found, 1);
    repeat (3) @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("rstw_busy", busy, 0);
    check("rstw_ack", ack, 0);
    check("rstw_start", conv_start, 0);
    check("rstw_conv_value", conv_value, 0);
    check("rstw_an", an, 4'b1110);
    check("rstw_bcd", bcd_out, 0);
    check("rstw_err", err, 0);
    req0 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    acks = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ack != 2'b00 || busy) acks++;
    end
    check("rstw_no_ack_after", acks, 0);
    fixed_lat = 0;

    // both requesting continuously: strict alternation starting at 0
    @(negedge clk);
    val0 = 14'd111;
    val1 = 14'd222;
    req0 = 1'b1;
    req1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      grants[k] = 2'b00;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (ack != 2'b00) begin
          grants[k] = ack;
          break;
        end
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_grant%0d", k), grants[k], (k % 2 == 1) ? 2'b10 : 2'b01);

    // randomized two-requester traffic with display switching
    fork
      drive(0, 30);
      drive(1, 30);
      begin
        while (drv_done < 2) begin
          @(negedge clk);
          if ($urandom_range(0, 9) == 0) disp_sel = ~disp_sel;
        end
      end
    join

    repeat (120) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
